// File: rtl/mux2_rr_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mux2_rr_arbiter_pkg
//   Shared definitions for the two-requester round-robin arbiter.
//   - SEL_IN0 / SEL_IN1 : encoding of the 2:1 datapath mux select / grant
//   - rr_grant()        : combinational grant decision from the two valids and
//                         the last-grant priority bit
// -----------------------------------------------------------------------------
package mux2_rr_arbiter_pkg;

    localparam logic SEL_IN0 = 1'b0;
    localparam logic SEL_IN1 = 1'b1;

    // A lone requester always wins. On a tie, or with no requester at all,
    // the priority bit decides; holding it when idle keeps sel stable.
    function automatic logic rr_grant(
        input logic v0,
        input logic v1,
        input logic prio
    );
        logic g;
        g = prio;
        if (v0 && !v1) begin
            g = SEL_IN0;
        end else if (v1 && !v0) begin
            g = SEL_IN1;
        end
        return g;
    endfunction

endpackage

// File: rtl/mux2_rr_arbiter_mux2_nb.sv
// -----------------------------------------------------------------------------
// mux2_1b / mux2_nb
//   mux2_1b : single-bit gate-level 2:1 mux.
//             Ports: in0, in1 (data), sel (0 -> in0, 1 -> in1), out.
//   mux2_nb : p_nbits-wide 2:1 mux built by replicating mux2_1b per bit.
//             Ports: in0, in1 [p_nbits], sel, out [p_nbits].
// -----------------------------------------------------------------------------
module mux2_1b (
    input  logic in0,
    input  logic in1,
    input  logic sel,
    output logic out
);

    logic sel_n;
    logic and0;
    logic and1;

    assign sel_n = ~sel;
    assign and0  = in0 & sel_n;
    assign and1  = in1 & sel;
    assign out   = and0 | and1;

endmodule

module mux2_nb #(
    parameter int p_nbits = 32
) (
    input  logic [p_nbits-1:0] in0,
    input  logic [p_nbits-1:0] in1,
    input  logic               sel,
    output logic [p_nbits-1:0] out
);

    for (genvar i = 0; i < p_nbits; i++) begin : g_bit
        mux2_1b u_mux (
            .in0 (in0[i]),
            .in1 (in1[i]),
            .sel (sel),
            .out (out[i])
        );
    end

endmodule

// File: rtl/mux2_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mux2_rr_arbiter
//   Shares one p_nbits-wide val/rdy channel between two val/rdy producers.
//   A last-grant priority bit gives round-robin fairness on contention; the
//   winning message is steered through a 2:1 mux into a one-entry output
//   buffer that may drain and refill on the same edge.
//
//   Ports
//     clk      : system clock, rising edge
//     reset    : asynchronous, active-low reset (0 = in reset)
//     in0_val  : requester 0 valid      in0_rdy : requester 0 accepted
//     in0_msg  : requester 0 message
//     in1_val  : requester 1 valid      in1_rdy : requester 1 accepted
//     in1_msg  : requester 1 message
//     out_val  : buffer holds a message out_rdy : downstream accepts
//     out_msg  : buffered message
//     sel      : current grant / mux select (0 = in0, 1 = in1)
// -----------------------------------------------------------------------------
module mux2_rr_arbiter
    import mux2_rr_arbiter_pkg::*;
#(
    parameter int p_nbits = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in0_val,
    output logic               in0_rdy,
    input  logic [p_nbits-1:0] in0_msg,
    input  logic               in1_val,
    output logic               in1_rdy,
    input  logic [p_nbits-1:0] in1_msg,
    output logic               out_val,
    input  logic               out_rdy,
    output logic [p_nbits-1:0] out_msg,
    output logic               sel
);

    logic               vld_p1;
    logic [p_nbits-1:0] msg_p1;
    logic               prio_p1;

    logic               can_accept;
    logic               grant;
    logic               in_xfer;
    logic               out_xfer;
    logic [p_nbits-1:0] mux_msg;

    // ---- stage 0: grant, handshake and input steering ----
    assign grant      = rr_grant(in0_val, in1_val, prio_p1);
    assign can_accept = !vld_p1 || out_rdy;

    // reset gates rdy directly so both drop the instant reset asserts.
    assign in0_rdy  = reset && can_accept && (grant == SEL_IN0);
    assign in1_rdy  = reset && can_accept && (grant == SEL_IN1);

    assign in_xfer  = (in0_val && in0_rdy) || (in1_val && in1_rdy);
    assign out_xfer = vld_p1 && out_rdy;

    mux2_nb #(
        .p_nbits (p_nbits)
    ) u_mux (
        .in0 (in0_msg),
        .in1 (in1_msg),
        .sel (grant),
        .out (mux_msg)
    );

    // ---- stage 1: output buffer and last-grant priority ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_p1  <= 1'b0;
            msg_p1  <= '0;
            prio_p1 <= SEL_IN0;
        end else begin
            if (in_xfer) begin
                // A fill wins over a concurrent drain: the buffer stays full
                // and simply takes the new message.
                vld_p1  <= 1'b1;
                msg_p1  <= mux_msg;
                prio_p1 <= ~grant;
            end else if (out_xfer) begin
                vld_p1  <= 1'b0;
            end
        end
    end

    assign out_val = vld_p1;
    assign out_msg = msg_p1;
    assign sel     = grant;

endmodule

// File: doc/mux2_rr_arbiter.md
# mux2_rr_arbiter

Two-requester round-robin arbiter with a one-entry registered output buffer. It shares a single p_nbits-wide downstream channel between two val/rdy producers, such as instruction-fetch and data-memory ports contending for one memory bus in the TinyRV1 processor. It drives the select of a 2:1 datapath mux and registers the winning message. Fairness is enforced by a last-grant priority register.

## Interface
- p_nbits, 32, message width in bits
- clk  input  1  system clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-low reset (0 = in reset)
- in0_val  input  1  requester 0 has a valid message
- in0_rdy  output  1  arbiter accepts requester 0 this cycle
- in0_msg  input  p_nbits  requester 0 message
- in1_val  input  1  requester 1 has a valid message
- in1_rdy  output  1  arbiter accepts requester 1 this cycle
- in1_msg  input  p_nbits  requester 1 message
- out_val  output  1  output buffer holds a valid message
- out_rdy  input  1  downstream accepts the output message
- out_msg  output  p_nbits  buffered message
- sel  output  1  current mux select / grant (0 = in0, 1 = in1)

## Operation
- State: full (1 bit), buf (p_nbits), prio (1 bit; the requester that wins a tie).
- can_accept = !full || out_rdy. The buffer may drain and refill in the same cycle.
- Grant logic is combinational:
  - Only in0_val set: sel=0.
  - Only in1_val set: sel=1.
  - Both set: sel=prio.
  - Neither set: sel=prio (don't-care, held stable).
- inN_rdy = reset && can_accept && (sel==N). At most one rdy is high in any cycle. A rdy never depends on the same requester's own val beyond the grant decision.
- Transfer on input N when inN_val && inN_rdy. On that edge:
  - buf <= inN_msg (via mux, sel=N)
  - full <= 1
  - prio <= !N
- Output transfer when out_val && out_rdy. If no input transfer happens in the same cycle, full <= 0.
- prio changes only on an input transfer. A lone requester may issue back-to-back with no forced idle.
- out_msg = buf. out_val = full. buf holds its value when full=0 (no reset of stale data required beyond reset value).

## Timing
- Reset (reset=0, asynchronous): full=0, out_val=0, buf=0 so out_msg=0, prio=0, in0_rdy=in1_rdy=0. Outputs take these values immediately, without waiting for a clock edge.
- First edge after reset deasserts: normal operation. A request at that edge is accepted.
- Latency: input accepted at edge k appears on out_val/out_msg after edge k, i.e. 1 cycle.
- Throughput: 1 message per cycle while out_rdy=1.
- Backpressure: full=1 and out_rdy=0 force both rdy low. buf and prio hold.
- Simultaneous drain and fill at one edge: full stays 1 and buf takes the new message.
- Reset asserted mid-transfer: the buffered message is discarded. No output transfer occurs during reset.

## Structure
- Shared package: none needed. sel encoding constants SEL_IN0=1'b0 and SEL_IN1=1'b1 go in the existing common defines.
- One natural sub-module: mux2_nb, a p_nbits-wide 2:1 mux (in0, in1, sel, out) built by replicating the team's 1-bit gate-level 2:1 mux. The arbiter contains the control logic, the prio/full flops, and the buf register.

## Test plan
- Reset: hold reset=0 with in0_val=in1_val=1 -> out_val=0, out_msg=0, both rdy=0. Release reset -> next edge accepts in0 (prio=0).
- Single requester: in0_val=1, in0_msg=0x11, then 0x22 in consecutive cycles, out_rdy=1 -> out_msg 0x11 then 0x22 on successive cycles, in1_rdy=0 throughout.
- Contention: both val=1 for 4 cycles, in0_msg=0xA0, in1_msg=0xB0, out_rdy=1 -> outputs alternate A0, B0, A0, B0, and sel alternates 0,1,0,1.
- Backpressure: buffer full with 0x33, out_rdy=0 for 3 cycles, in1_val=1 -> both rdy=0, out_msg stays 0x33. Raise out_rdy -> 0x33 drains and in1's message is accepted the same edge.
- Simultaneous drain/fill: full=1, out_rdy=1, in1_val=1 with msg 0x44 -> out_val stays 1 and out_msg=0x44 on the next cycle.
- Mid-operation reset: full=1 with 0x55, pulse reset=0 between edges -> out_val drops to 0 immediately and prio=0 after release.
